mem_request_arbiter: RTL and testbench

//  Responder for the fetch/load/store requests the decode logic raises (instrread, memread, memwrite).

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/mem_watchdog.sv | 41 ++++
 rtl/mem_request_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the memory request arbiter and its helpers.
package cpu_types_pkg;

  localparam int unsigned ARB_ADDR_W  = 32;
  localparam int unsigned ARB_DATA_W  = 32;
  localparam int unsigned ARB_TIMEOUT = 255;

  typedef logic [ARB_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // True while a RAM transaction is in flight.
  function automatic logic is_busy(input arb_state_t s);
    return (s == DATA) || (s == INSTR);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Saturating cycle counter used to abort a RAM transaction that never acks.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over enable; the count sticks at CNT_MAX instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates an instruction port and a data port onto a single-ported RAM.
// Data accesses win over fetches; one transaction outstanding at a time.
module mem_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W      = ARB_ADDR_W,
  parameter int unsigned DATA_W      = ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              bus_err
);

  arb_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q,    we_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic              dhit_q,  dhit_d;
  logic              ihit_q,  ihit_d;
  logic              bus_err_q, bus_err_d;

  logic wd_clear_s;
  logic wd_en_s;
  logic timeout_s;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (CLK),
    .rst       (RST),
    .clear_i   (wd_clear_s),
    .en_i      (wd_en_s),
    .timeout_o (timeout_s)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ack beats a simultaneous timeout; DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DATA;
        end else if (iREN) begin
          state_d = INSTR;
        end else begin
          state_d = IDLE;
        end
      end
      DATA, INSTR: begin
        if (ram_ack) begin
          state_d = DONE;
        end else if (timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch the request in IDLE, capture data and hits on ack.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    dload_d    = dload_q;
    iload_d    = iload_q;
    dhit_d     = 1'b0;
    ihit_d     = 1'b0;
    bus_err_d  = bus_err_q;
    wd_clear_s = 1'b0;
    wd_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          addr_d     = daddr;
          wdata_d    = dstore;
          we_d       = dWEN;
          wd_clear_s = 1'b1;
        end else if (iREN) begin
          addr_d     = iaddr;
          we_d       = 1'b0;
          wd_clear_s = 1'b1;
        end else begin
          wd_clear_s = 1'b0;
        end
      end
      DATA: begin
        if (ram_ack) begin
          dload_d = ram_rdata;
          dhit_d  = 1'b1;
        end else begin
          wd_en_s = 1'b1;
          if (timeout_s) begin
            bus_err_d = 1'b1;
          end else begin
            bus_err_d = bus_err_q;
          end
        end
      end
      INSTR: begin
        if (ram_ack) begin
          iload_d = ram_rdata;
          ihit_d  = 1'b1;
        end else begin
          wd_en_s = 1'b1;
          if (timeout_s) begin
            bus_err_d = 1'b1;
          end else begin
            bus_err_d = bus_err_q;
          end
        end
      end
      DONE:    wd_en_s = 1'b0;
      default: wd_en_s = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      we_q      <= 1'b0;
      dload_q   <= {DATA_W{1'b0}};
      iload_q   <= {DATA_W{1'b0}};
      dhit_q    <= 1'b0;
      ihit_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      dload_q   <= dload_d;
      iload_q   <= iload_d;
      dhit_q    <= dhit_d;
      ihit_q    <= ihit_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign ram_req   = is_busy(state_q);
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign dload     = dload_q;
  assign iload     = iload_q;
  assign dhit      = dhit_q;
  assign ihit      = ihit_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter.
module tb_mem_request_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dstore = 32'h0;
  logic [31:0] dload;
  logic        dhit;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic        ram_ack = 1'b0;
  logic        bus_err;

  int tests_run = 0;
  int tests_failed = 0;
  int ihit_cnt = 0;
  int dhit_cnt = 0;
  int overlap_cnt = 0;
  int base_i;
  int base_d;

  mem_request_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .ihit      (ihit),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dhit      (dhit),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_ack   (ram_ack),
    .bus_err   (bus_err)
  );

  always #5 CLK = ~CLK;

  // Count hit pulses away from the active edge.
  always @(negedge CLK) begin
    if (ihit) ihit_cnt++;
    if (dhit) dhit_cnt++;
    if (ihit && dhit) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Ack the in-flight request after 'delay' cycles (delay>=1), returning in the hit cycle.
  task automatic do_ack(input logic [31:0] data, input int delay);
    for (int i = 1; i < delay; i++) step();
    ram_ack   = 1'b1;
    ram_rdata = data;
    step();
    ram_ack   = 1'b0;
    ram_rdata = 32'h0;
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_req", {31'd0, ram_req}, 32'd0);
    chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
    chk("rst_berr", {31'd0, bus_err}, 32'd0);
    chk("rst_iload", iload, 32'd0);
    RST = 1'b0;
    step();

    // Stray ack in IDLE is ignored
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    step();
    chk("idle_ack_req", {31'd0, ram_req}, 32'd0);
    chk("idle_ack_hits", ihit_cnt + dhit_cnt, 32'd0);

    // Fetch, ack after 2 cycles
    iREN = 1'b1; iaddr = 32'h0000_0040;
    step();
    chk("f_req", {31'd0, ram_req}, 32'd1);
    chk("f_addr", ram_addr, 32'h0000_0040);
    chk("f_we", {31'd0, ram_we}, 32'd0);
    do_ack(32'h2001_0005, 2);
    chk("f_ihit", {31'd0, ihit}, 32'd1);
    chk("f_iload", iload, 32'h2001_0005);
    chk("f_req_drop", {31'd0, ram_req}, 32'd0);
    iREN = 1'b0;
    step();
    chk("f_ihit_off", {31'd0, ihit}, 32'd0);
    chk("f_iload_hold", iload, 32'h2001_0005);
    chk("f_ihit_cnt", ihit_cnt, 32'd1);

    // Store, ack after 1 cycle
    dWEN = 1'b1; daddr = 32'h0000_0100; dstore = 32'hDEAD_BEEF;
    step();
    chk("s_we", {31'd0, ram_we}, 32'd1);
    chk("s_addr", ram_addr, 32'h0000_0100);
    chk("s_wdata", ram_wdata, 32'hDEAD_BEEF);
    do_ack(32'h0, 1);
    chk("s_dhit", {31'd0, dhit}, 32'd1);
    dWEN = 1'b0;
    step();
    chk("s_dhit_cnt", dhit_cnt, 32'd1);

    // Contention: data first, then fetch after DONE (back-to-back)
    base_i = ihit_cnt; base_d = dhit_cnt;
    iREN = 1'b1; iaddr = 32'h0000_0200;
    dREN = 1'b1; daddr = 32'h0000_0300;
    step();
    chk("c_addr_d", ram_addr, 32'h0000_0300);
    chk("c_we_d", {31'd0, ram_we}, 32'd0);
    do_ack(32'h1111_1111, 1);
    chk("c_dhit", {30'd0, ihit, dhit}, 32'd1);
    chk("c_dload", dload, 32'h1111_1111);
    dREN = 1'b0;
    step();
    chk("c_done_noreq", {31'd0, ram_req}, 32'd0);
    step();
    chk("c_req_i", {31'd0, ram_req}, 32'd1);
    chk("c_addr_i", ram_addr, 32'h0000_0200);
    do_ack(32'h2222_2222, 3);
    chk("c_ihit", {30'd0, ihit, dhit}, 32'd2);
    chk("c_iload", iload, 32'h2222_2222);
    chk("c_dload_hold", dload, 32'h1111_1111);
    iREN = 1'b0;
    step();
    chk("c_cnt", (ihit_cnt - base_i) * 16 + (dhit_cnt - base_d), 32'h11);
    chk("c_overlap", overlap_cnt, 32'd0);

    // Timeout: no ack for 255 cycles, then fetch still completes
    base_i = ihit_cnt;
    iREN = 1'b1; iaddr = 32'h0000_0400;
    step();
    for (int i = 0; i < 255; i++) step();
    chk("t_req_before", {31'd0, ram_req}, 32'd1);
    chk("t_berr_before", {31'd0, bus_err}, 32'd0);
    iaddr = 32'h0000_0044;
    step();
    chk("t_req_drop", {31'd0, ram_req}, 32'd0);
    chk("t_berr", {31'd0, bus_err}, 32'd1);
    chk("t_nohit", ihit_cnt - base_i, 32'd0);
    step();
    chk("t_refetch_addr", ram_addr, 32'h0000_0044);
    do_ack(32'hCAFE_F00D, 1);
    chk("t_refetch_ihit", {31'd0, ihit}, 32'd1);
    chk("t_refetch_iload", iload, 32'hCAFE_F00D);
    chk("t_berr_sticky", {31'd0, bus_err}, 32'd1);
    iREN = 1'b0;
    step();

    // Async reset mid-DATA
    base_d = dhit_cnt;
    dREN = 1'b1; daddr = 32'h0000_0500;
    step();
    chk("r_req", {31'd0, ram_req}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("r_req_async", {31'd0, ram_req}, 32'd0);
    chk("r_berr_async", {31'd0, bus_err}, 32'd0);
    chk("r_iload_async", iload, 32'd0);
    dREN = 1'b0;
    step();
    RST = 1'b0;
    step();
    chk("r_nohit", dhit_cnt - base_d, 32'd0);
    dREN = 1'b1; daddr = 32'h0000_0504;
    step();
    chk("r_restart_addr", ram_addr, 32'h0000_0504);
    do_ack(32'h5555_AAAA, 2);
    chk("r_dhit", {31'd0, dhit}, 32'd1);
    chk("r_dload", dload, 32'h5555_AAAA);
    dREN = 1'b0;
    step();
    chk("r_dhit_cnt", dhit_cnt - base_d, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
